// File: rtl/mips_mc_pkg.sv
// mips_mc_pkg: shared encodings for the multi-cycle MIPS controller.
//   - state_t    : 4-bit FSM state encoding (also exported on state_dbg)
//   - OP_*       : instruction opcodes, IR[31:26]
//   - FN_*       : R-type funct codes, IR[5:0]
//   - ALU_*      : 4-bit ALU operation codes driven to the datapath ALU
//   - ALUOP_*    : internal 2-bit alu_op from the main FSM to the ALU decoder
package mips_mc_pkg;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADR  = 4'd3,
    S_MEMRD   = 4'd4,
    S_MEMWB   = 4'd5,
    S_MEMWR   = 4'd6,
    S_EXECUTE = 4'd7,
    S_ALUWB   = 4'd8,
    S_BRANCH  = 4'd9,
    S_ADDIEX  = 4'd10,
    S_ADDIWB  = 4'd11,
    S_JUMP    = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOP = 4'b1111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // True when funct names an R-type operation the ALU implements.
  function automatic logic funct_supported(input logic [5:0] funct);
    case (funct)
      FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: funct_supported = 1'b1;
      default:                               funct_supported = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mips_alu_decoder.sv
// mips_alu_decoder: combinational ALU-control decoder.
//   alu_op   in  2  operation class from the main FSM (add / sub / by funct)
//   funct    in  6  IR[5:0], consulted only when alu_op selects funct
//   alu_ctrl out 4  ALU operation code; unknown funct yields ALU_NOP
module mips_alu_decoder
  import mips_mc_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [3:0] alu_ctrl
);

  always_comb begin
    alu_ctrl = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_ctrl = ALU_ADD;
      ALUOP_SUB: alu_ctrl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alu_ctrl = ALU_ADD;
          FN_SUB:  alu_ctrl = ALU_SUB;
          FN_AND:  alu_ctrl = ALU_AND;
          FN_OR:   alu_ctrl = ALU_OR;
          FN_SLT:  alu_ctrl = ALU_SLT;
          default: alu_ctrl = ALU_NOP;
        endcase
      end
      default: alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_mc_control.sv
// mips_mc_control: multi-cycle MIPS main controller (Moore FSM) plus ALU
// control. Sequences fetch/decode/execute/memory/writeback and drives every
// datapath select and enable.
//   clk, rst_n        clock, asynchronous active-low reset (to IDLE)
//   opcode, funct     IR fields (stable after FETCH)
//   zero              ALU zero flag, used only in BRANCH
//   mem_ready         memory finishes the current access this cycle
//   pc_en, ir_write, i_or_d, mem_write, reg_write, reg_dst, mem_to_reg,
//   alu_src_a, alu_src_b, pc_src, alu_ctrl   datapath controls
//   illegal_instr     one-cycle pulse in DECODE on unsupported opcode/funct
//   state_dbg         current state encoding
module mips_mc_control
  import mips_mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       ir_write,
  output logic       i_or_d,
  output logic       mem_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic [3:0] alu_ctrl,
  output logic       illegal_instr,
  output logic [3:0] state_dbg
);

  state_t     state;
  state_t     next_state;
  logic       pc_write;
  logic       branch;
  logic [1:0] alu_op;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  next_state = S_FETCH;
      S_FETCH: next_state = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_RTYPE:     next_state = S_EXECUTE;
          OP_BEQ:       next_state = S_BRANCH;
          OP_ADDI:      next_state = S_ADDIEX;
          OP_J:         next_state = S_JUMP;
          default:      next_state = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        case (opcode)
          OP_LW:   next_state = S_MEMRD;
          OP_SW:   next_state = S_MEMWR;
          default: next_state = S_FETCH;
        endcase
      end
      S_MEMRD:   next_state = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:   next_state = S_FETCH;
      S_MEMWR:   next_state = mem_ready ? S_FETCH : S_MEMWR;
      S_EXECUTE: next_state = S_ALUWB;
      S_ALUWB:   next_state = S_FETCH;
      S_BRANCH:  next_state = S_FETCH;
      S_ADDIEX:  next_state = S_ADDIWB;
      S_ADDIWB:  next_state = S_FETCH;
      S_JUMP:    next_state = S_FETCH;
      default:   next_state = S_IDLE;
    endcase
  end

  always_comb begin
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    branch        = 1'b0;
    i_or_d        = 1'b0;
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    pc_src        = 2'b00;
    alu_op        = ALUOP_ADD;
    illegal_instr = 1'b0;
    case (state)
      S_FETCH: begin
        // PC+4 and IR capture only land once memory returns the word.
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        // Speculative branch target into ALUOut.
        alu_src_b = 2'b11;
        case (opcode)
          OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: illegal_instr = 1'b0;
          OP_RTYPE: illegal_instr = ~funct_supported(funct);
          default:  illegal_instr = 1'b1;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD: i_or_d = 1'b1;
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      S_MEMWR: begin
        i_or_d    = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_SUB;
        branch    = 1'b1;
        pc_src    = 2'b01;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_ADDIWB: reg_write = 1'b1;
      S_JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
      end
      default: ;
    endcase
  end

  assign pc_en     = pc_write | (branch & zero);
  assign state_dbg = state;

  mips_alu_decoder u_alu_decoder (
    .alu_op   (alu_op),
    .funct    (funct),
    .alu_ctrl (alu_ctrl)
  );

endmodule

// File: tb/tb_mips_mc_control.sv
// tb_mips_mc_control: directed self-checking bench for mips_mc_control.
// Each step compares the full packed output vector against a hand-written
// expectation built with mk().
module tb_mips_mc_control;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       pc_en;
  logic       ir_write;
  logic       i_or_d;
  logic       mem_write;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_src;
  logic [3:0] alu_ctrl;
  logic       illegal_instr;
  logic [3:0] state_dbg;

  int compared   = 0;
  int mismatched = 0;

  mips_mc_control dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .opcode        (opcode),
    .funct         (funct),
    .zero          (zero),
    .mem_ready     (mem_ready),
    .pc_en         (pc_en),
    .ir_write      (ir_write),
    .i_or_d        (i_or_d),
    .mem_write     (mem_write),
    .reg_write     (reg_write),
    .reg_dst       (reg_dst),
    .mem_to_reg    (mem_to_reg),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .pc_src        (pc_src),
    .alu_ctrl      (alu_ctrl),
    .illegal_instr (illegal_instr),
    .state_dbg     (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {pc_en, ir_write, i_or_d, mem_write, reg_write, reg_dst, mem_to_reg,
  //  alu_src_a, alu_src_b, pc_src, alu_ctrl, illegal_instr, state_dbg}
  logic [20:0] obs;
  assign obs = {pc_en, ir_write, i_or_d, mem_write, reg_write, reg_dst,
                mem_to_reg, alu_src_a, alu_src_b, pc_src, alu_ctrl,
                illegal_instr, state_dbg};

  function automatic logic [20:0] mk(
    input logic [3:0] st,
    input logic pe, input logic ir, input logic iod, input logic mw,
    input logic rw, input logic rd, input logic m2r, input logic sa,
    input logic [1:0] sb, input logic [1:0] ps, input logic [3:0] ac,
    input logic ill);
    mk = {pe, ir, iod, mw, rw, rd, m2r, sa, sb, ps, ac, ill, st};
  endfunction

  task automatic chk(input string tag, input logic [20:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Common expectations (state, pe, ir, iod, mw, rw, rd, m2r, sa, sb, ps, ac, ill)
  logic [20:0] E_IDLE, E_FETCH, E_FETCH_STALL, E_DECODE, E_DECODE_ILL;
  logic [20:0] E_MEMADR, E_MEMRD, E_MEMWB, E_MEMWR, E_ALUWB;
  logic [20:0] E_ADDIEX, E_ADDIWB, E_JUMP;

  logic [5:0] fn_tab [5];
  logic [3:0] ac_tab [5];

  initial begin
    E_IDLE        = mk(4'd0,  0,0,0,0,0,0,0,0, 2'b00, 2'b00, 4'b0010, 0);
    E_FETCH       = mk(4'd1,  1,1,0,0,0,0,0,0, 2'b01, 2'b00, 4'b0010, 0);
    E_FETCH_STALL = mk(4'd1,  0,0,0,0,0,0,0,0, 2'b01, 2'b00, 4'b0010, 0);
    E_DECODE      = mk(4'd2,  0,0,0,0,0,0,0,0, 2'b11, 2'b00, 4'b0010, 0);
    E_DECODE_ILL  = mk(4'd2,  0,0,0,0,0,0,0,0, 2'b11, 2'b00, 4'b0010, 1);
    E_MEMADR      = mk(4'd3,  0,0,0,0,0,0,0,1, 2'b10, 2'b00, 4'b0010, 0);
    E_MEMRD       = mk(4'd4,  0,0,1,0,0,0,0,0, 2'b00, 2'b00, 4'b0010, 0);
    E_MEMWB       = mk(4'd5,  0,0,0,0,1,0,1,0, 2'b00, 2'b00, 4'b0010, 0);
    E_MEMWR       = mk(4'd6,  0,0,1,1,0,0,0,0, 2'b00, 2'b00, 4'b0010, 0);
    E_ALUWB       = mk(4'd8,  0,0,0,0,1,1,0,0, 2'b00, 2'b00, 4'b0010, 0);
    E_ADDIEX      = mk(4'd10, 0,0,0,0,0,0,0,1, 2'b10, 2'b00, 4'b0010, 0);
    E_ADDIWB      = mk(4'd11, 0,0,0,0,1,0,0,0, 2'b00, 2'b00, 4'b0010, 0);
    E_JUMP        = mk(4'd12, 1,0,0,0,0,0,0,0, 2'b00, 2'b10, 4'b0010, 0);

    fn_tab[0] = 6'b100000; ac_tab[0] = 4'b0010;
    fn_tab[1] = 6'b100010; ac_tab[1] = 4'b0110;
    fn_tab[2] = 6'b100100; ac_tab[2] = 4'b0000;
    fn_tab[3] = 6'b100101; ac_tab[3] = 4'b0001;
    fn_tab[4] = 6'b101010; ac_tab[4] = 4'b0111;

    rst_n = 1'b0; opcode = 6'b0; funct = 6'b0; zero = 1'b0; mem_ready = 1'b1;

    // Reset held 3 cycles
    repeat (3) tick();
    chk("reset_idle", E_IDLE);
    rst_n = 1'b1;
    tick();
    chk("restart_fetch", E_FETCH);

    // FETCH stall: enables gated off
    mem_ready = 1'b0;
    #1 chk("fetch_stall", E_FETCH_STALL);
    tick();
    chk("fetch_stall_hold", E_FETCH_STALL);
    mem_ready = 1'b1;
    #1 chk("fetch_ready", E_FETCH);

    // R-type: add, sub, and, or, slt
    opcode = 6'b000000;
    for (int i = 0; i < 5; i++) begin
      funct = fn_tab[i];
      tick(); chk($sformatf("rtype%0d_decode", i), E_DECODE);
      tick(); chk($sformatf("rtype%0d_execute", i),
                  mk(4'd7, 0,0,0,0,0,0,0,1, 2'b00, 2'b00, ac_tab[i], 0));
      tick(); chk($sformatf("rtype%0d_aluwb", i), E_ALUWB);
      tick(); chk($sformatf("rtype%0d_fetch", i), E_FETCH);
    end

    // lw with two stall cycles in MEMRD (7 cycles total)
    opcode = 6'b100011;
    tick(); chk("lw_decode", E_DECODE);
    tick(); chk("lw_memadr", E_MEMADR);
    mem_ready = 1'b0;
    tick(); chk("lw_memrd1", E_MEMRD);
    tick(); chk("lw_memrd2", E_MEMRD);
    tick(); chk("lw_memrd3", E_MEMRD);
    mem_ready = 1'b1;
    tick(); chk("lw_memwb", E_MEMWB);
    tick(); chk("lw_fetch", E_FETCH);

    // sw
    opcode = 6'b101011;
    tick(); chk("sw_decode", E_DECODE);
    tick(); chk("sw_memadr", E_MEMADR);
    tick(); chk("sw_memwr", E_MEMWR);
    tick(); chk("sw_fetch", E_FETCH);

    // beq taken; zero high in DECODE must not raise pc_en
    opcode = 6'b000100;
    tick(); zero = 1'b1;
    #1 chk("beq1_decode_zero", E_DECODE);
    tick(); chk("beq1_branch", mk(4'd9, 1,0,0,0,0,0,0,1, 2'b00, 2'b01, 4'b0110, 0));
    tick(); chk("beq1_fetch", E_FETCH);

    // beq not taken
    zero = 1'b0;
    tick(); chk("beq0_decode", E_DECODE);
    tick(); chk("beq0_branch", mk(4'd9, 0,0,0,0,0,0,0,1, 2'b00, 2'b01, 4'b0110, 0));
    tick(); chk("beq0_fetch", E_FETCH);

    // addi
    opcode = 6'b001000;
    tick(); chk("addi_decode", E_DECODE);
    tick(); chk("addi_ex", E_ADDIEX);
    tick(); chk("addi_wb", E_ADDIWB);
    tick(); chk("addi_fetch", E_FETCH);

    // j
    opcode = 6'b000010;
    tick(); chk("j_decode", E_DECODE);
    tick(); chk("j_jump", E_JUMP);
    tick(); chk("j_fetch", E_FETCH);

    // Illegal opcode: single-cycle pulse then FETCH
    opcode = 6'b111111;
    tick(); chk("illop_decode", E_DECODE_ILL);
    tick(); chk("illop_fetch", E_FETCH);

    // Illegal funct: pulse in DECODE, NOP in EXECUTE, still writes back
    opcode = 6'b000000; funct = 6'b111111;
    tick(); chk("illfn_decode", E_DECODE_ILL);
    tick(); chk("illfn_execute", mk(4'd7, 0,0,0,0,0,0,0,1, 2'b00, 2'b00, 4'b1111, 0));
    tick(); chk("illfn_aluwb", E_ALUWB);
    tick(); chk("illfn_fetch", E_FETCH);

    // Reset during a stalled MEMWR
    opcode = 6'b101011; funct = 6'b100000;
    tick(); chk("rst_sw_decode", E_DECODE);
    tick(); chk("rst_sw_memadr", E_MEMADR);
    mem_ready = 1'b0;
    tick(); chk("rst_sw_memwr", E_MEMWR);
    tick(); chk("rst_sw_memwr_hold", E_MEMWR);
    rst_n = 1'b0;
    #1 chk("rst_async_idle", E_IDLE);
    mem_ready = 1'b1;
    tick(); chk("rst_held_idle", E_IDLE);
    rst_n = 1'b1;
    tick(); chk("rst_restart_fetch", E_FETCH);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mips_mc_control.md
Name: mips_mc_control

Overview:
- Multi-cycle MIPS main controller plus ALU-control decoder. It is the driving end of the ALU interface: it issues the 4-bit ALU operation code and consumes the ALU zero flag for beq.
- It sequences fetch, decode, execute, memory and writeback.
- It emits every datapath mux select and write enable.
- It sits beside the datapath (PC, IR, register file, ALU, unified memory).

Parameters:
- none.
- All encodings live in the shared package.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- pc_en  out  1  PC load enable
- ir_write  out  1  IR load
- i_or_d  out  1  memory address select: 0=PC, 1=ALUOut
- mem_write  out  1  memory write request
- reg_write  out  1  register file write
- reg_dst  out  1  destination register: 0=rt, 1=rd
- mem_to_reg  out  1  write data: 0=ALUOut, 1=MDR
- alu_src_a  out  1  ALU A: 0=PC, 1=rs
- alu_src_b  out  2  ALU B: 00=rt, 01=const 4, 10=sign-extended imm, 11=imm<<2
- pc_src  out  2  next PC: 00=ALU result, 01=ALUOut, 10=jump target
- alu_ctrl  out  4  ALU operation: 0010 add, 0110 sub, 0000 and, 0001 or, 0111 slt
- illegal_instr  out  1  one-cycle pulse in DECODE on an unsupported opcode or funct
- state_dbg  out  4  current state encoding

Behaviour:
- Moore FSM. One state register updates on posedge clk; rst_n low clears it asynchronously to IDLE.
- All outputs decode combinationally from the state, except:
  - pc_en = pc_write | (branch & zero)
  - gating of ir_write/pc_write by mem_ready
- Unlisted outputs are 0 in every state. Internal alu_op is 00 unless stated.

States:
- IDLE: all outputs 0, alu_ctrl=0010. Next state: FETCH. Also the state during and after reset.
- FETCH: i_or_d=0, alu_src_a=0, alu_src_b=01, ir_write=pc_write=mem_ready. Stays in FETCH while mem_ready=0; goes to DECODE when it is 1.
- DECODE: alu_src_a=0, alu_src_b=11 (precomputes branch target). Next state by opcode:
  - 100011 lw or 101011 sw -> MEMADR
  - 000000 R-type -> EXECUTE
  - 000100 beq -> BRANCH
  - 001000 addi -> ADDIEX
  - 000010 j -> JUMP
  - other opcode -> FETCH, with illegal_instr=1
- MEMADR: alu_src_a=1, alu_src_b=10. Next: lw -> MEMRD, sw -> MEMWR.
- MEMRD: i_or_d=1. Holds until mem_ready, then goes to MEMWB.
- MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1. Next: FETCH.
- MEMWR: i_or_d=1, mem_write=1. Held until mem_ready, then goes to FETCH. mem_write stays high across the stall.
- EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10. Next: ALUWB.
- ALUWB: reg_dst=1, reg_write=1. Next: FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, branch=1, pc_src=01. Next: FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10. Next: ADDIWB.
- ADDIWB: reg_write=1. Next: FETCH.
- JUMP: pc_src=10, pc_write=1. Next: FETCH.

ALU decoder (combinational):
- alu_op 00 -> 0010; alu_op 01 -> 0110.
- alu_op 10 uses funct: 100000 -> 0010, 100010 -> 0110, 100100 -> 0000, 100101 -> 0001, 101010 -> 0111.
- Unknown funct -> 1111 (ALU yields 0).
- A funct-illegal R-type still completes through ALUWB (writes 0). illegal_instr pulses in its DECODE cycle.

Cycle counts (mem_ready held 1, including FETCH): R-type 4, lw 5, sw 4, beq 3, addi 4, j 3.

Boundary conditions:
- mem_ready low stretches FETCH, MEMRD and MEMWR indefinitely. No enable other than mem_write is asserted while stalled.
- zero is sampled only in BRANCH. zero toggling in other states has no effect on pc_en.
- opcode/funct are used only in DECODE, EXECUTE and MEMADR. The IR is stable after FETCH, so no registering is needed.
- Reset mid-instruction aborts immediately to IDLE: all enables drop asynchronously, nothing completes. Restart is IDLE -> FETCH after rst_n rises.

Decomposition:
- Package mips_mc_pkg holds:
  - state enum (4-bit)
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J
  - funct constants
  - ALU control codes: ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_NOP=1111
  - alu_op codes
- Sub-module mips_alu_decoder: combinational, alu_op + funct -> alu_ctrl.

Test Plan:
- Reset/idle: hold rst_n=0 for 3 cycles -> state_dbg=IDLE, all enables 0. Release -> FETCH next cycle, pc_en=ir_write=1.
- R-type add: opcode=000000, funct=100000, mem_ready=1 -> sequence FETCH, DECODE, EXECUTE (alu_ctrl=0010, alu_src_b=00), ALUWB (reg_write=1, reg_dst=1), then FETCH. Repeat for sub=0110, and=0000, or=0001, slt=0111.
- lw with stall: opcode=100011, mem_ready low for 2 cycles in MEMRD -> MEMRD held 3 cycles with i_or_d=1, then MEMWB with mem_to_reg=1. Total 7 cycles.
- beq: opcode=000100. zero=1 in BRANCH -> pc_en=1, pc_src=01, alu_ctrl=0110. zero=0 -> pc_en=0. Each completes in 3 cycles.
- Illegal cases:
  - opcode=111111 -> illegal_instr high exactly 1 cycle (DECODE), then FETCH.
  - funct=111111 R-type -> alu_ctrl=1111 in EXECUTE, illegal_instr pulse.
- Mid-operation reset: assert rst_n low during MEMWR while mem_ready=0 -> mem_write drops the same cycle (asynchronously), state_dbg=IDLE.
